// File: rtl/nexys_starship_repair_lock.sv
// Combo-lock repair engine: latches a hex challenge for a broken room,
// checks switch submissions, and pulses repaired or fail.
module nexys_starship_repair_lock #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int TIMEOUT_CYC  = 500_000_000,
  parameter int TO_W         = 29
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] broken_req,
  input  logic [3:0] rand_hex,
  input  logic [3:0] sw_combo,
  input  logic       submit_pulse,
  output logic [3:0] challenge_hex,
  output logic [3:0] active_room,
  output logic [1:0] attempts_left,
  output logic [3:0] repaired,
  output logic       fail,
  output logic       q_Idle,
  output logic       q_Arm,
  output logic       q_Wait,
  output logic       q_Check,
  output logic       q_Done,
  output logic       q_Fail
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ARM   = 6'b000010,
    S_WAIT  = 6'b000100,
    S_CHECK = 6'b001000,
    S_DONE  = 6'b010000,
    S_FAIL  = 6'b100000
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      ATT_MAX = 2'(MAX_ATTEMPTS);

  state_e          state_q, state_d;
  logic [3:0]      chal_q, chal_d;
  logic [3:0]      room_q, room_d;
  logic [1:0]      att_q, att_d;
  logic [3:0]      rep_q, rep_d;
  logic            fail_q, fail_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      pick;

  // Fixed priority: top > btm > left > right
  always_comb begin
    pick = 4'b0000;
    if (broken_req[3])      pick = 4'b1000;
    else if (broken_req[2]) pick = 4'b0100;
    else if (broken_req[1]) pick = 4'b0010;
    else if (broken_req[0]) pick = 4'b0001;
  end

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    room_d  = room_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    rep_d   = 4'b0000;
    fail_d  = 1'b0;
    if (game_over || !play_flag) begin
      state_d = S_IDLE;
      room_d  = 4'b0000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (broken_req != 4'b0000) begin
            state_d = S_ARM;
            room_d  = pick;
          end
        end
        S_ARM: begin
          // Never hand out a challenge the switches already match
          chal_d  = (rand_hex == sw_combo) ? ~rand_hex : rand_hex;
          att_d   = ATT_MAX;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + TO_W'(1);
          if ((broken_req & room_q) == 4'b0000) begin
            state_d = S_IDLE;
            room_d  = 4'b0000;
          end else if (submit_pulse) begin
            state_d = S_CHECK;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end
        end
        S_CHECK: begin
          if (sw_combo == chal_q) begin
            state_d = S_DONE;
            rep_d   = room_q;
          end else if (att_q <= 2'd1) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            att_d   = att_q - 2'd1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
        S_DONE, S_FAIL: begin
          state_d = S_IDLE;
          room_d  = 4'b0000;
        end
        default: begin
          state_d = S_IDLE;
          room_d  = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      chal_q  <= 4'h0;
      room_q  <= 4'b0000;
      att_q   <= ATT_MAX;
      rep_q   <= 4'b0000;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      room_q  <= room_d;
      att_q   <= att_d;
      rep_q   <= rep_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign challenge_hex = chal_q;
  assign active_room   = room_q;
  assign attempts_left = att_q;
  assign repaired      = rep_q;
  assign fail          = fail_q;
  assign q_Idle        = state_q[0];
  assign q_Arm         = state_q[1];
  assign q_Wait        = state_q[2];
  assign q_Check       = state_q[3];
  assign q_Done        = state_q[4];
  assign q_Fail        = state_q[5];

endmodule

// File: tb/tb_nexys_starship_repair_lock.sv
// Bench for the repair lock: directed scenarios plus randomized
// repair sessions checked against a transaction-level model.
module tb_nexys_starship_repair_lock;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] broken_req = 4'h0;
  logic [3:0] rand_hex = 4'h0;
  logic [3:0] sw_combo = 4'h0;
  logic       submit_pulse = 1'b0;
  logic [3:0] challenge_hex;
  logic [3:0] active_room;
  logic [1:0] attempts_left;
  logic [3:0] repaired;
  logic       fail;
  logic       q_Idle, q_Arm, q_Wait, q_Check, q_Done, q_Fail;

  logic [5:0] st;
  assign st = {q_Fail, q_Done, q_Check, q_Wait, q_Arm, q_Idle};

  localparam logic [5:0] IDLE  = 6'b000001;
  localparam logic [5:0] ARM   = 6'b000010;
  localparam logic [5:0] WAIT  = 6'b000100;
  localparam logic [5:0] CHECK = 6'b001000;
  localparam logic [5:0] DONE  = 6'b010000;
  localparam logic [5:0] FAILS = 6'b100000;

  int checks = 0;
  int passes = 0;

  // Model state for the current session
  logic [3:0] m_room;
  logic [3:0] m_chal;
  int         m_att;
  bit         m_over;

  always #5 Clk = ~Clk;

  nexys_starship_repair_lock #(
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYC (16),
    .TO_W        (5)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .play_flag    (play_flag),
    .game_over    (game_over),
    .broken_req   (broken_req),
    .rand_hex     (rand_hex),
    .sw_combo     (sw_combo),
    .submit_pulse (submit_pulse),
    .challenge_hex(challenge_hex),
    .active_room  (active_room),
    .attempts_left(attempts_left),
    .repaired     (repaired),
    .fail         (fail),
    .q_Idle       (q_Idle),
    .q_Arm        (q_Arm),
    .q_Wait       (q_Wait),
    .q_Check      (q_Check),
    .q_Done       (q_Done),
    .q_Fail       (q_Fail)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref_room(input logic [3:0] br);
    for (int i = 3; i >= 0; i--)
      if (br[i]) return 4'(1 << i);
    return 4'h0;
  endfunction

  function automatic logic [3:0] ref_chal(input logic [3:0] rh,
                                          input logic [3:0] sw);
    return (rh == sw) ? ~rh : rh;
  endfunction

  task automatic arm(input logic [3:0] br, input logic [3:0] rh,
                     input logic [3:0] sw);
    play_flag  = 1'b1;
    broken_req = br;
    rand_hex   = rh;
    sw_combo   = sw;
    m_room     = ref_room(br);
    m_chal     = ref_chal(rh, sw);
    m_att      = 3;
    m_over     = 1'b0;
    tick();
    chk("arm_state", 8'(st), 8'(ARM));
    chk("arm_room", 8'(active_room), 8'(m_room));
    tick();
    chk("wait_state", 8'(st), 8'(WAIT));
    chk("challenge", 8'(challenge_hex), 8'(m_chal));
    chk("att_init", 8'(attempts_left), 8'd3);
  endtask

  task automatic submit(input logic [3:0] sw);
    sw_combo     = sw;
    submit_pulse = 1'b1;
    tick();
    submit_pulse = 1'b0;
    chk("check_state", 8'(st), 8'(CHECK));
    chk("check_no_rep", 8'(repaired), 8'h0);
    tick();
    if (sw == m_chal) begin
      chk("done_state", 8'(st), 8'(DONE));
      chk("repaired", 8'(repaired), 8'(m_room));
      chk("done_no_fail", 8'(fail), 8'h0);
      m_over = 1'b1;
    end else if (m_att == 1) begin
      chk("lock_state", 8'(st), 8'(FAILS));
      chk("lock_fail", 8'(fail), 8'h1);
      chk("lock_no_rep", 8'(repaired), 8'h0);
      m_over = 1'b1;
    end else begin
      m_att--;
      chk("retry_state", 8'(st), 8'(WAIT));
      chk("retry_att", 8'(attempts_left), 8'(m_att));
    end
    if (m_over) begin
      tick();
      chk("end_idle", 8'(st), 8'(IDLE));
      chk("end_room", 8'(active_room), 8'h0);
      chk("end_pulses", {3'b0, fail, repaired}, 8'h0);
    end
  endtask

  initial begin
    logic [3:0] br, rh, sw, w;
    int nwrong;

    // Reset state
    tick();
    tick();
    chk("rst_state", 8'(st), 8'(IDLE));
    chk("rst_att", 8'(attempts_left), 8'd3);
    chk("rst_outs", {challenge_hex, active_room}, 8'h00);
    chk("rst_pulses", {3'b0, fail, repaired}, 8'h0);
    Reset = 1'b1;
    tick();

    // btm selected, correct submit, latency of repaired
    arm(4'b0110, 4'h7, 4'h0);
    submit(4'h7);

    // Three wrong submits lock out
    arm(4'b0110, 4'h7, 4'h0);
    submit(4'h1);
    submit(4'h2);
    submit(4'h3);

    // Timeout after 16 wait cycles
    arm(4'b1000, 4'h3, 4'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_still_wait", 8'(st), 8'(WAIT));
    chk("to_no_fail_yet", 8'(fail), 8'h0);
    tick();
    chk("to_fail_state", 8'(st), 8'(FAILS));
    chk("to_fail", 8'(fail), 8'h1);
    tick();
    chk("to_idle", 8'(st), 8'(IDLE));

    // Submit on the last wait cycle beats the timeout
    arm(4'b1000, 4'h3, 4'h0);
    for (int i = 0; i < 15; i++) tick();
    submit(4'h3);

    // Free-solve guard
    arm(4'b0001, 4'h5, 4'h5);
    chk("guard_chal", 8'(challenge_hex), 8'h0A);
    submit(4'hA);

    // game_over abort in wait
    arm(4'b0010, 4'h9, 4'h0);
    game_over = 1'b1;
    tick();
    chk("abort_state", 8'(st), 8'(IDLE));
    chk("abort_room", 8'(active_room), 8'h0);
    chk("abort_pulses", {3'b0, fail, repaired}, 8'h0);
    game_over = 1'b0;

    // Room cleared externally
    arm(4'b0011, 4'h4, 4'h0);
    broken_req = 4'b0001;
    tick();
    chk("clear_state", 8'(st), 8'(IDLE));
    chk("clear_pulses", {3'b0, fail, repaired}, 8'h0);
    chk("clear_room", 8'(active_room), 8'h0);

    // Asynchronous reset mid-wait
    arm(4'b0100, 4'hC, 4'h0);
    submit(4'h1);
    tick();
    Reset = 1'b0;
    #1;
    chk("arst_state", 8'(st), 8'(IDLE));
    chk("arst_att", 8'(attempts_left), 8'd3);
    chk("arst_outs", {challenge_hex, active_room}, 8'h00);
    tick();
    Reset = 1'b1;
    broken_req = 4'h0;
    tick();

    // Randomized sessions
    for (int n = 0; n < 24; n++) begin
      br = 4'($urandom_range(1, 15));
      rh = 4'($urandom);
      sw = ($urandom_range(0, 3) == 0) ? rh : 4'($urandom);
      arm(br, rh, sw);
      broken_req = 4'($urandom) | m_room;
      tick();
      chk("room_hold", 8'(active_room), 8'(m_room));
      nwrong = $urandom_range(0, 3);
      for (int k = 0; k < nwrong; k++) begin
        w = m_chal ^ 4'($urandom_range(1, 15));
        submit(w);
      end
      if (!m_over) submit(m_chal);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
